// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared types and helpers for the instruction fetch stage.
//   fetch_state_e : fetch controller states
//   fetch_entry_t : one buffered instruction {ir, pc}
//   FETCH_DEFAULT_RESET_PC : PC of the first fetch after reset
//   next_word()   : sequential PC increment (wraps at 32 bits)
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        FETCH_RUN    = 2'b00,
        FETCH_HALTED = 2'b01,
        FETCH_FAULT  = 2'b10
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] ir;
        logic [31:0] pc;
    } fetch_entry_t;

    localparam logic [31:0] FETCH_DEFAULT_RESET_PC = 32'h0000_0000;

    function automatic logic [31:0] next_word(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction-memory request/response channel and the
// instruction handshake towards decode.
//   master : fetch side (drives requests and ir_*)
//   slave  : memory/decoder side
interface fetch_unit_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        ir_valid;
    logic        ir_ready;
    logic [31:0] ir;
    logic [31:0] ir_pc;

    modport master (
        output imem_req_valid, imem_req_addr, ir_valid, ir, ir_pc,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, ir_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, ir_valid, ir, ir_pc,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, ir_ready
    );
endinterface

// File: rtl/fetch_unit_queue.sv
// fetch_queue: in-order FIFO of {ir, pc} entries.
//   clk, rst     : clock, async active-high reset
//   flush_i      : empty the queue (wins over push/pop)
//   push_i       : write push_data_i at the tail
//   pop_i        : drop the head entry
//   head_o       : head entry, valid_o when non-empty
//   count_o      : number of stored entries
module fetch_queue
    import fetch_unit_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  fetch_entry_t               push_data_i,
    input  logic                       pop_i,
    output fetch_entry_t               head_o,
    output logic                       valid_o,
    output logic [$clog2(DEPTH):0]     count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fetch_entry_t    mem_q [DEPTH];
    logic [AW-1:0]   wr_q, rd_q;
    logic [CW-1:0]   count_q;

    // Storage carries no reset; head_o is only meaningful while valid_o.
    always_ff @(posedge clk) begin
        if (push_i && !flush_i) begin
            mem_q[wr_q] <= push_data_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else if (flush_i) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            if (push_i) wr_q <= wr_q + AW'(1);
            if (pop_i)  rd_q <= rd_q + AW'(1);
            count_q <= count_q + CW'(push_i) - CW'(pop_i);
        end
    end

    assign head_o  = mem_q[rd_q];
    assign valid_o = (count_q != '0);
    assign count_o = count_q;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: RV32I instruction fetch stage. Holds the PC, issues word reads
// to instruction memory, buffers responses in order and hands them to decode.
// Handles redirects from execute and halt from decode, discarding stale
// in-flight responses.
//   clk, rst           : clock, async active-high reset
//   bus (master)       : imem request/response channel and ir handshake
//   redirect_valid_i   : taken branch / jump resolved
//   redirect_pc_i      : new fetch target
//   halt_i             : decoded halt, sticky until reset
//   misalign_fault_o   : misaligned redirect target seen (sticky)
// Optional feature macro: FETCH_ALIGN_CHECK_EN (misaligned redirect -> FAULT).
//
// state        | meaning
// FETCH_RUN    | fetching, redirects and halt accepted
// FETCH_HALTED | halted by decode; no requests, late responses absorbed
// FETCH_FAULT  | as HALTED, misalign_fault_o high
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = FETCH_DEFAULT_RESET_PC,
    parameter int          DEPTH    = 2
) (
    input  logic              clk,
    input  logic              rst,
    fetch_unit_if.master      bus,
    input  logic              redirect_valid_i,
    input  logic [31:0]       redirect_pc_i,
    input  logic              halt_i,
    output logic              misalign_fault_o
);
    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_e  state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [31:0]   rsp_pc_q, rsp_pc_d;
    logic [CW-1:0] out_q, out_d;
    logic [CW-1:0] drop_q, drop_d;

    logic          q_flush, q_push, q_pop, q_valid;
    fetch_entry_t  q_head;
    logic [CW-1:0] q_count;
    logic [CW:0]   occ;
    logic          req_valid, req_fire;
    logic          redir_bad;
    logic [31:0]   redir_target;

`ifdef FETCH_ALIGN_CHECK_EN
    assign redir_bad        = (redirect_pc_i[1:0] != 2'b00);
    assign redir_target     = redirect_pc_i;
    assign misalign_fault_o = (state_q == FETCH_FAULT);
`else
    assign redir_bad        = 1'b0;
    assign redir_target     = redirect_pc_i & ~32'h3;
    assign misalign_fault_o = 1'b0;
`endif

    fetch_queue #(.DEPTH(DEPTH)) u_queue (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (q_flush),
        .push_i      (q_push),
        .push_data_i ('{ir: bus.imem_rsp_data, pc: rsp_pc_q}),
        .pop_i       (q_pop),
        .head_o      (q_head),
        .valid_o     (q_valid),
        .count_o     (q_count)
    );

    assign q_pop = q_valid && bus.ir_ready;

    // Every request must have a queue slot when its response lands. A pop this
    // cycle frees a slot before any new response can be pushed, so it is
    // credited here; that is what sustains one instruction per cycle.
    assign occ       = {1'b0, out_q} + {1'b0, q_count} - {{CW{1'b0}}, q_pop};
    assign req_valid = !rst && (state_q == FETCH_RUN) && !redirect_valid_i
                       && !halt_i && (occ < (CW+1)'(DEPTH));
    assign req_fire  = req_valid && bus.imem_req_ready;

    assign bus.imem_req_valid = req_valid;
    assign bus.imem_req_addr  = pc_q;
    assign bus.ir_valid       = q_valid;
    assign bus.ir             = q_valid ? q_head.ir : 32'h0;
    assign bus.ir_pc          = q_valid ? q_head.pc : 32'h0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= FETCH_RUN;
            pc_q     <= RESET_PC;
            rsp_pc_q <= RESET_PC;
            out_q    <= '0;
            drop_q   <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            rsp_pc_q <= rsp_pc_d;
            out_q    <= out_d;
            drop_q   <= drop_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        rsp_pc_d = rsp_pc_q;
        out_d    = out_q;
        drop_d   = drop_q;
        q_flush  = 1'b0;
        q_push   = 1'b0;

        if (bus.imem_rsp_valid) begin
            out_d = out_q - CW'(1);
            if (drop_q != '0) begin
                drop_d = drop_q - CW'(1);
            end else if (state_q == FETCH_RUN) begin
                q_push   = 1'b1;
                rsp_pc_d = next_word(rsp_pc_q);
            end
        end

        if (req_fire) begin
            out_d = out_d + CW'(1);
            pc_d  = next_word(pc_q);
        end

        if (state_q == FETCH_RUN) begin
            if (redirect_valid_i) begin
                q_flush = 1'b1;
                q_push  = 1'b0;
                if (redir_bad) begin
                    state_d = FETCH_FAULT;
                end else begin
                    // No request goes out this cycle, so out_d is exactly the
                    // set of still-pending stale responses.
                    drop_d   = out_d;
                    pc_d     = redir_target;
                    rsp_pc_d = redir_target;
                end
            end else if (halt_i) begin
                q_flush = 1'b1;
                q_push  = 1'b0;
                state_d = FETCH_HALTED;
            end
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        halt = 1'b0;
    logic        misalign_fault;

    fetch_unit_if ifc ();

    fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) u_dut (
        .clk              (clk),
        .rst              (rst),
        .bus              (ifc.master),
        .redirect_valid_i (redirect_valid),
        .redirect_pc_i    (redirect_pc),
        .halt_i           (halt),
        .misalign_fault_o (misalign_fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [31:0] addr;
    } mreq_t;

    mreq_t       memq[$];
    int          con_cycles[$];
    logic [31:0] con_pcs[$];
    logic [31:0] req_log[$];

    int          cycle;
    int          lat;
    int          n_checks;
    int          n_fail;
    int          n_req;
    logic        nop_mem;
    logic [31:0] exp_pc;
    logic [31:0] exp_req;
    logic        stopped;
    logic        fault_exp;

    function automatic logic [31:0] memw(input logic [31:0] a, input logic nop);
        return nop ? 32'h0000_0013 : ((a * 32'h9E37_79B1) ^ 32'h0000_0013);
    endfunction

    task automatic do_reset(input int latency, input logic nop);
        rst = 1'b1;
        ifc.imem_req_ready = 1'b0;
        ifc.imem_rsp_valid = 1'b0;
        ifc.imem_rsp_data  = 32'h0;
        ifc.ir_ready       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        halt           = 1'b0;
        memq.delete();
        con_cycles.delete();
        con_pcs.delete();
        req_log.delete();
        lat       = latency;
        nop_mem   = nop;
        exp_pc    = RESET_PC;
        exp_req   = RESET_PC;
        stopped   = 1'b0;
        fault_exp = 1'b0;
        n_req     = 0;
        repeat (2) @(posedge clk);
        @(posedge clk);
        #2;
        rst   = 1'b0;
        cycle = 0;
    endtask

    // One clock cycle: memory response, drive inputs, check against the model.
    task automatic step(input logic rdy_ir, input logic rdy_req, input logic redir,
                        input logic [31:0] rpc, input logic hlt);
        logic [31:0] a;
        @(negedge clk);
        ifc.imem_rsp_valid = 1'b0;
        ifc.imem_rsp_data  = 32'h0;
        if (memq.size() > 0 && memq[0].due == cycle) begin
            ifc.imem_rsp_valid = 1'b1;
            ifc.imem_rsp_data  = memw(memq[0].addr, nop_mem);
            void'(memq.pop_front());
        end
        ifc.ir_ready       = rdy_ir && !redir && !hlt;
        ifc.imem_req_ready = rdy_req;
        redirect_valid     = redir;
        redirect_pc        = rpc;
        halt               = hlt;
        #1;
        n_checks++;
        if (misalign_fault !== fault_exp) begin
            n_fail++;
            $display("FAIL misalign_fault c%0d: got %b expected %b", cycle, misalign_fault, fault_exp);
        end
        if (stopped) begin
            n_checks++;
            if (ifc.ir_valid !== 1'b0 || ifc.imem_req_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL stopped_idle c%0d: got ir_valid=%b req_valid=%b expected 0/0",
                         cycle, ifc.ir_valid, ifc.imem_req_valid);
            end
        end
        if (ifc.ir_valid === 1'b1 && ifc.ir_ready) begin
            n_checks++;
            if (ifc.ir_pc !== exp_pc || ifc.ir !== memw(exp_pc, nop_mem)) begin
                n_fail++;
                $display("FAIL ir_stream c%0d: got pc=%h ir=%h expected pc=%h ir=%h",
                         cycle, ifc.ir_pc, ifc.ir, exp_pc, memw(exp_pc, nop_mem));
            end
            con_cycles.push_back(cycle);
            con_pcs.push_back(ifc.ir_pc);
            exp_pc = exp_pc + 32'd4;
        end
        if (!stopped && (redir || hlt)) begin
            n_checks++;
            if (ifc.imem_req_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL req_in_ctl_cycle c%0d: got req_valid=%b expected 0", cycle, ifc.imem_req_valid);
            end
        end
        if (ifc.imem_req_valid === 1'b1 && rdy_req) begin
            a = ifc.imem_req_addr;
            n_checks++;
            if (a !== exp_req) begin
                n_fail++;
                $display("FAIL req_addr c%0d: got %h expected %h", cycle, a, exp_req);
            end
            memq.push_back('{due: cycle + lat, addr: a});
            req_log.push_back(a);
            exp_req = exp_req + 32'd4;
            n_req++;
            n_checks++;
            if (memq.size() > DEPTH) begin
                n_fail++;
                $display("FAIL inflight_bound c%0d: got %0d expected <= %0d", cycle, memq.size(), DEPTH);
            end
        end
        if (!stopped) begin
            if (redir) begin
`ifdef FETCH_ALIGN_CHECK_EN
                if (rpc[1:0] != 2'b00) begin
                    stopped   = 1'b1;
                    fault_exp = 1'b1;
                end else begin
                    exp_pc  = rpc;
                    exp_req = rpc;
                end
`else
                exp_pc  = rpc & ~32'h3;
                exp_req = rpc & ~32'h3;
`endif
            end else if (hlt) begin
                stopped = 1'b1;
            end
        end
        @(posedge clk);
        cycle++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (ifc.imem_req_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_req_valid: got %b expected 0", ifc.imem_req_valid);
        end
        do_reset(1, 1'b1);
        #1;
        n_checks++;
        if (ifc.imem_req_valid !== 1'b1 || ifc.imem_req_addr !== RESET_PC) begin
            n_fail++;
            $display("FAIL reset_first_req: got valid=%b addr=%h expected 1/%h",
                     ifc.imem_req_valid, ifc.imem_req_addr, RESET_PC);
        end
        n_checks++;
        if (ifc.ir_valid !== 1'b0 || ifc.ir !== 32'h0 || ifc.ir_pc !== 32'h0 || misalign_fault !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got ir_valid=%b ir=%h ir_pc=%h fault=%b expected 0/0/0/0",
                     ifc.ir_valid, ifc.ir, ifc.ir_pc, misalign_fault);
        end
    endtask

    task automatic test_sequential();
        do_reset(1, 1'b1);
        repeat (8) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        n_checks++;
        if (con_cycles.size() < 4) begin
            n_fail++;
            $display("FAIL seq_count: got %0d expected >= 4", con_cycles.size());
        end else begin
            n_checks++;
            if (con_cycles[0] != 2) begin
                n_fail++;
                $display("FAIL seq_first_latency: got %0d expected 2", con_cycles[0]);
            end
            for (int i = 1; i < 4; i++) begin
                n_checks++;
                if (con_cycles[i] != con_cycles[0] + i || con_pcs[i] !== 32'(4 * i)) begin
                    n_fail++;
                    $display("FAIL seq_back_to_back[%0d]: got c%0d pc=%h expected c%0d pc=%h",
                             i, con_cycles[i], con_pcs[i], con_cycles[0] + i, 32'(4 * i));
                end
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset(1, 1'b0);
        repeat (10) step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        n_checks++;
        if (n_req != DEPTH || ifc.imem_req_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_requests: got %0d reqs valid=%b expected %0d/0", n_req, ifc.imem_req_valid, DEPTH);
        end
        repeat (12) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        n_checks++;
        if (con_pcs.size() < DEPTH || con_pcs[0] !== 32'h0 || con_pcs[1] !== 32'h4) begin
            n_fail++;
            $display("FAIL bp_no_loss: got %0d consumed expected >= %0d starting 0,4", con_pcs.size(), DEPTH);
        end
    endtask

    task automatic test_redirect();
        do_reset(3, 1'b0);
        repeat (2) step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 32'h0000_0100, 1'b0);
        #1;
        n_checks++;
        if (ifc.ir_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL redirect_ir_valid: got %b expected 0", ifc.ir_valid);
        end
        con_pcs.delete();
        repeat (20) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        n_checks++;
        if (con_pcs.size() == 0 || con_pcs[0] !== 32'h0000_0100) begin
            n_fail++;
            $display("FAIL redirect_target: got %0d words first=%h expected first=00000100",
                     con_pcs.size(), (con_pcs.size() > 0) ? con_pcs[0] : 32'hx);
        end
    endtask

    task automatic test_halt();
        do_reset(2, 1'b0);
        repeat (6) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
        #1;
        n_checks++;
        if (ifc.ir_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL halt_ir_valid: got %b expected 0", ifc.ir_valid);
        end
        n_req = 0;
        for (int i = 0; i < 10; i++) step(1'b1, 1'b1, (i % 2) == 0, 32'h0000_0200, 1'b0);
        n_checks++;
        if (n_req != 0) begin
            n_fail++;
            $display("FAIL halt_no_requests: got %0d expected 0", n_req);
        end
    endtask

    task automatic test_misalign();
        do_reset(1, 1'b0);
        repeat (4) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 32'h0000_0102, 1'b0);
`ifdef FETCH_ALIGN_CHECK_EN
        #1;
        n_checks++;
        if (misalign_fault !== 1'b1) begin
            n_fail++;
            $display("FAIL misalign_set: got %b expected 1", misalign_fault);
        end
        n_req = 0;
        repeat (5) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        n_checks++;
        if (n_req != 0) begin
            n_fail++;
            $display("FAIL misalign_stop: got %0d reqs expected 0", n_req);
        end
`else
        req_log.delete();
        repeat (2) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        n_checks++;
        if (req_log.size() == 0 || req_log[0] !== 32'h0000_0100) begin
            n_fail++;
            $display("FAIL misalign_forced: got %0d reqs first=%h expected first=00000100",
                     req_log.size(), (req_log.size() > 0) ? req_log[0] : 32'hx);
        end
`endif
    endtask

    task automatic test_wrap();
        do_reset(1, 1'b0);
        repeat (2) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0);
        req_log.delete();
        repeat (6) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        n_checks++;
        if (req_log.size() < 2 || req_log[0] !== 32'hFFFF_FFFC || req_log[1] !== 32'h0000_0000) begin
            n_fail++;
            $display("FAIL pc_wrap: got %0d reqs expected FFFFFFFC then 00000000", req_log.size());
        end
    endtask

    task automatic test_random();
        logic [31:0] tgt;
        logic        rd;
        for (int r = 0; r < 3; r++) begin
            do_reset(1 + r, 1'b0);
            for (int i = 0; i < 600; i++) begin
                rd  = ($urandom % 100) < 3;
                tgt = 32'($urandom_range(0, 255)) << 2;
                step(($urandom % 100) < 70, ($urandom % 100) < 80, rd, tgt, 1'b0);
            end
            n_checks++;
            if (con_pcs.size() < 100) begin
                n_fail++;
                $display("FAIL random_progress[%0d]: got %0d consumed expected >= 100", r, con_pcs.size());
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        cycle    = 0;
        ifc.imem_req_ready = 1'b0;
        ifc.imem_rsp_valid = 1'b0;
        ifc.imem_rsp_data  = 32'h0;
        ifc.ir_ready       = 1'b0;
        test_reset();
        test_sequential();
        test_backpressure();
        test_redirect();
        test_halt();
        test_misalign();
        test_wrap();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
